mdu: RTL and testbench
======================

Name: mdu

Overview:
- E-stage multiply/divide unit of the pipelined MIPS core.
- Consumes the forwarded rs/rt operand values read from the D-stage register file and owns the architectural HI/LO registers.
- Models the multi-cycle latency of mult/multu/div/divu and reports busy so the hazard unit can stall mfhi/mflo and further MD instructions in D.
- mthi/mtlo write HI/LO directly.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
- DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
- clk  input  1  clock
- reset  input  1  sync reset, active-high
- start  input  1  valid MD instruction in E this cycle
- op  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE)
- flush  input  1  E-stage instruction cancelled (exception/interrupt in M); suppresses start
- rs_val  input  32  forwarded rs operand
- rt_val  input  32  forwarded rt operand
- busy  output  1  multi-cycle operation in progress
- stall_req  output  1  combinational: busy | (start & ~flush & op in 1..4)
- hi  output  32  architectural HI
- lo  output  32  architectural LO

Behaviour:
- Reset: synchronous, active-high, reset = clk and reset ports above.
  - busy=0, hi=0, lo=0, counter=0, state IDLE.
  - Reset mid-operation discards the pending result.
- States:
  - IDLE (counter==0).
  - RUN (counter!=0).
  - busy = (state==RUN), registered.
- Accepted start: start=1, flush=0, state IDLE, op 1..4, at edge t.
  - Compute the 64-bit result in that edge into pending_hi/pending_lo.
  - Load counter with MULT_CYCLES or DIV_CYCLES and go to RUN.
- RUN:
  - counter decrements each edge.
  - At the edge where counter goes 1->0, hi<=pending_hi, lo<=pending_lo, return to IDLE.
  - Hence busy=1 for exactly N cycles after the start edge; hi/lo show old values while busy and new values in the first cycle busy=0.
- MTHI/MTLO:
  - Accepted only in IDLE with flush=0.
  - hi<=rs_val (MTHI) or lo<=rs_val (MTLO) at that edge; busy stays 0.
- Ignored starts (hazard unit guarantees these never occur; they are still required to have no effect):
  - start while RUN: ignored, no state change.
  - flush=1 blocks a new start or mt* write that cycle.
- flush does not abort an operation already in RUN; it completes normally.
- Arithmetic:
  - MULT: signed 32x32 -> 64, hi=[63:32], lo=[31:0].
  - MULTU: zero-extended operands.
  - DIV: lo = quotient truncated toward zero, hi = remainder with the sign of the dividend (rs/rt).
    - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - DIVU: unsigned quotient/remainder.
  - Divide by zero: see optional feature; busy timing is unchanged (DIV_CYCLES).
- Back-to-back: a new start is accepted in the same cycle busy first reads 0, i.e. the edge after completion.

Optional Feature:
- Macro: MDU_DIVZERO_EN.
- Defined: div/divu with rt_val==0 writes lo=0xFFFFFFFF, hi=rs_val at completion.
- Undefined: divide by zero leaves hi/lo unchanged at completion; busy still asserted DIV_CYCLES cycles.

Test Plan:
- Reset, then MULT rs=0xFFFFFFFE (-2), rt=3 -> busy=1 exactly 5 cycles; afterwards hi=0xFFFFFFFF, lo=0xFFFFFFFA; hi/lo stay 0 while busy.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 5 busy cycles.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU rs=7, rt=2 -> lo=3, hi=1.
- MTHI rs=0x12345678 idle -> hi=0x12345678 next cycle, busy never rises; MTLO with flush=1 -> lo unchanged.
- Start MULT, assert start+DIV during busy, then reset on cycle 3 -> second start ignored; after reset busy=0, hi=lo=0, no late write.
- DIV rs=5, rt=0 with hi=0xAA, lo=0xBB -> unchanged without MDU_DIVZERO_EN; hi=5, lo=0xFFFFFFFF with it; stall_req=1 in the start cycle in both builds.

Source files
------------

// File: rtl/mdu_if.sv
// Operand/command and result bundle between the E stage and the MDU.
interface mdu_if;
   logic        start;
   logic [2:0]  op;
   logic        flush;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        busy;
   logic        stall_req;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output start, op, flush, rs_val, rt_val,
      input  busy, stall_req, hi, lo
   );

   modport slave (
      input  start, op, flush, rs_val, rt_val,
      output busy, stall_req, hi, lo
   );
endinterface

// File: rtl/mdu.sv
// E-stage multiply/divide unit owning HI/LO with modelled multi-cycle latency.
// Define MDU_DIVZERO_EN for lo=all-ones, hi=dividend on divide by zero.
module mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input logic clk,
   input logic reset,
   mdu_if.slave bus
);
   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ?
                         MULT_CYCLES : DIV_CYCLES;
   localparam int CW = $clog2(MAXC + 1);
   localparam logic [CW-1:0] MC = CW'(MULT_CYCLES);
   localparam logic [CW-1:0] DC = CW'(DIV_CYCLES);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [31:0]   hi_q, hi_n, lo_q, lo_n;
   logic [31:0]   phi, phi_n, plo, plo_n;
   logic          pwr, pwr_n;

   logic          go, md_op, dz;
   logic [31:0]   rs, rt;
   logic signed [63:0] sa64, sb64, prod_s;
   logic [63:0]   prod_u;
   logic [31:0]   a_abs, b_abs, b_sdiv, b_udiv;
   logic [31:0]   qa, ra, q_s, r_s, q_u, r_u;

   assign rs    = bus.rs_val;
   assign rt    = bus.rt_val;
   assign go    = bus.start & ~bus.flush;
   assign md_op = (bus.op >= OP_MULT) && (bus.op <= OP_DIVU);
   assign dz    = (rt == 32'd0);

   assign sa64   = {{32{rs[31]}}, rs};
   assign sb64   = {{32{rt[31]}}, rt};
   assign prod_s = sa64 * sb64;
   assign prod_u = {32'd0, rs} * {32'd0, rt};

   // Signed divide on magnitudes; divisor forced to 1 on zero to keep sim quiet
   assign a_abs  = rs[31] ? (~rs + 32'd1) : rs;
   assign b_abs  = rt[31] ? (~rt + 32'd1) : rt;
   assign b_sdiv = dz ? 32'd1 : b_abs;
   assign b_udiv = dz ? 32'd1 : rt;
   assign qa     = a_abs / b_sdiv;
   assign ra     = a_abs % b_sdiv;
   assign q_s    = (rs[31] ^ rt[31]) ? (~qa + 32'd1) : qa;
   assign r_s    = rs[31] ? (~ra + 32'd1) : ra;
   assign q_u    = rs / b_udiv;
   assign r_u    = rs % b_udiv;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
         phi   <= '0;
         plo   <= '0;
         pwr   <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         hi_q  <= hi_n;
         lo_q  <= lo_n;
         phi   <= phi_n;
         plo   <= plo_n;
         pwr   <= pwr_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      hi_n    = hi_q;
      lo_n    = lo_q;
      phi_n   = phi;
      plo_n   = plo;
      pwr_n   = pwr;
      unique case (state)
         IDLE: begin
            if (go) begin
               case (bus.op)
                  OP_MULT: begin
                     {phi_n, plo_n} = prod_s;
                     pwr_n   = 1'b1;
                     cnt_n   = MC;
                     state_n = RUN;
                  end
                  OP_MULTU: begin
                     {phi_n, plo_n} = prod_u;
                     pwr_n   = 1'b1;
                     cnt_n   = MC;
                     state_n = RUN;
                  end
                  OP_DIV, OP_DIVU: begin
                     if (bus.op == OP_DIV) begin
                        phi_n = r_s;
                        plo_n = q_s;
                     end else begin
                        phi_n = r_u;
                        plo_n = q_u;
                     end
                     pwr_n = 1'b1;
`ifdef MDU_DIVZERO_EN
                     if (dz) begin
                        phi_n = rs;
                        plo_n = 32'hFFFF_FFFF;
                     end
`else
                     if (dz) pwr_n = 1'b0;
`endif
                     cnt_n   = DC;
                     state_n = RUN;
                  end
                  OP_MTHI: hi_n = rs;
                  OP_MTLO: lo_n = rs;
                  default: ;
               endcase
            end
         end
         RUN: begin
            cnt_n = cnt - CW'(1);
            if (cnt == CW'(1)) begin
               state_n = IDLE;
               if (pwr) begin
                  hi_n = phi;
                  lo_n = plo;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.busy      = (state == RUN);
   assign bus.stall_req = (state == RUN) | (go & md_op);
   assign bus.hi        = hi_q;
   assign bus.lo        = lo_q;
endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: latency, arithmetic, mt*, flush, reset abort.
// Build with MDU_DIVZERO_EN defined to check the divide-by-zero write.
module tb_mdu;
   localparam int MC = 5;
   localparam int DC = 10;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad = 0;
   logic [63:0] sb[$];

   mdu_if bus ();

   mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] model(
      input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
      input logic [31:0] oh, input logic [31:0] ol);
      longint sa, sb2, q, r;
      logic [63:0] p;
      sa  = longint'($signed(a));
      sb2 = longint'($signed(b));
      p   = {oh, ol};
      if ((o == 3'd3 || o == 3'd4) && b == 32'd0) begin
`ifdef MDU_DIVZERO_EN
         p = {a, 32'hFFFF_FFFF};
`endif
         return p;
      end
      case (o)
         3'd1: p = 64'(sa * sb2);
         3'd2: p = {32'd0, a} * {32'd0, b};
         3'd3: begin
            q = sa / sb2;
            r = sa % sb2;
            p = {r[31:0], q[31:0]};
         end
         3'd4: p = {a % b, a / b};
         default: ;
      endcase
      return p;
   endfunction

   task automatic issue(input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int n, input string nm);
      logic [31:0] oh, ol;
      logic [63:0] e;
      int cyc;
      oh = bus.hi;
      ol = bus.lo;
      sb.push_back(model(o, a, b, oh, ol));
      bus.start = 1'b1; bus.op = o; bus.rs_val = a; bus.rt_val = b;
      #1;
      total++;
      if (bus.stall_req !== 1'b1) begin
         bad++;
         $display("FAIL %s stall_req got %b want 1", nm, bus.stall_req);
      end
      @(negedge clk);
      bus.start = 1'b0; bus.op = 3'd0;
      cyc = 0;
      while (bus.busy === 1'b1 && cyc < 64) begin
         total++;
         if (bus.hi !== oh || bus.lo !== ol) begin
            bad++;
            $display("FAIL %s hold got %h_%h want %h_%h",
                     nm, bus.hi, bus.lo, oh, ol);
         end
         cyc++;
         @(negedge clk);
      end
      total++;
      if (cyc != n) begin
         bad++;
         $display("FAIL %s busy_cycles got %0d want %0d", nm, cyc, n);
      end
      total++;
      if (sb.size() == 0) begin
         bad++;
         $display("FAIL %s scoreboard empty", nm);
      end else begin
         e = sb.pop_front();
         if ({bus.hi, bus.lo} !== e) begin
            bad++;
            $display("FAIL %s result got %h_%h want %h_%h",
                     nm, bus.hi, bus.lo, e[63:32], e[31:0]);
         end
      end
   endtask

   task automatic mt(input logic [2:0] o, input logic [31:0] a,
                     input logic f, input string nm);
      logic [31:0] eh, el;
      eh = bus.hi;
      el = bus.lo;
      if (!f && o == 3'd5) eh = a;
      if (!f && o == 3'd6) el = a;
      bus.start = 1'b1; bus.op = o; bus.rs_val = a; bus.flush = f;
      #1;
      total++;
      if (bus.stall_req !== 1'b0) begin
         bad++;
         $display("FAIL %s stall_req got %b want 0", nm, bus.stall_req);
      end
      @(negedge clk);
      bus.start = 1'b0; bus.op = 3'd0; bus.flush = 1'b0;
      total++;
      if (bus.busy !== 1'b0 || bus.hi !== eh || bus.lo !== el) begin
         bad++;
         $display("FAIL %s got busy=%b %h_%h want busy=0 %h_%h",
                  nm, bus.busy, bus.hi, bus.lo, eh, el);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.start = 1'b0; bus.op = 3'd0; bus.flush = 1'b0;
      bus.rs_val = '0; bus.rt_val = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      total++;
      if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0 ||
          bus.stall_req !== 1'b0) begin
         bad++;
         $display("FAIL reset got busy=%b stall=%b %h_%h want 0 0 0_0",
                  bus.busy, bus.stall_req, bus.hi, bus.lo);
      end
   endtask

   task automatic test_mult();
      issue(3'd1, 32'hFFFF_FFFE, 32'd3, MC, "mult_neg");
      issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MC, "multu_max");
   endtask

   task automatic test_div();
      issue(3'd3, 32'hFFFF_FFF9, 32'd2, DC, "div_neg");
      issue(3'd4, 32'd7, 32'd2, DC, "divu");
      issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, DC, "div_ovf");
      issue(3'd3, 32'd100, 32'hFFFF_FFF9, DC, "div_negrt");
   endtask

   task automatic test_mt();
      mt(3'd5, 32'h1234_5678, 1'b0, "mthi");
      mt(3'd6, 32'hDEAD_BEEF, 1'b1, "mtlo_flush");
      mt(3'd6, 32'h0BAD_F00D, 1'b0, "mtlo");
      mt(3'd7, 32'h5555_5555, 1'b0, "op_reserved");
      mt(3'd1, 32'h7, 1'b1, "mult_flush");
   endtask

   task automatic test_back_to_back();
      issue(3'd2, 32'h0001_0000, 32'h0001_0000, MC, "b2b_multu");
      issue(3'd4, 32'hFFFF_FFFF, 32'd16, DC, "b2b_divu");
      for (int i = 0; i < 4; i++) begin
         logic [31:0] a, b;
         logic [2:0] o;
         a = $urandom;
         b = $urandom | 32'd1;
         o = 3'(1 + (i % 4));
         issue(o, a, b, (o <= 3'd2) ? MC : DC, "b2b_rand");
      end
   endtask

   task automatic test_abort();
      bus.start = 1'b1; bus.op = 3'd1;
      bus.rs_val = 32'd3; bus.rt_val = 32'd4;
      @(negedge clk);
      bus.op = 3'd3; bus.rs_val = 32'd100; bus.rt_val = 32'd7;
      #1;
      total++;
      if (bus.busy !== 1'b1 || bus.stall_req !== 1'b1) begin
         bad++;
         $display("FAIL abort_busy got busy=%b stall=%b want 1 1",
                  bus.busy, bus.stall_req);
      end
      @(negedge clk);
      bus.start = 1'b0; bus.op = 3'd0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      total++;
      if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
         bad++;
         $display("FAIL abort_reset got busy=%b %h_%h want 0 0_0",
                  bus.busy, bus.hi, bus.lo);
      end
      repeat (DC + 4) @(negedge clk);
      total++;
      if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
         bad++;
         $display("FAIL abort_late got busy=%b %h_%h want 0 0_0",
                  bus.busy, bus.hi, bus.lo);
      end
   endtask

   task automatic test_divzero();
      mt(3'd5, 32'hAA, 1'b0, "dz_mthi");
      mt(3'd6, 32'hBB, 1'b0, "dz_mtlo");
      issue(3'd3, 32'd5, 32'd0, DC, "div_zero");
      issue(3'd4, 32'd9, 32'd0, DC, "divu_zero");
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_mt();
      test_back_to_back();
      test_abort();
      test_divzero();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
